// File: rtl/y_seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and the iteration counter width.
package y_seq_divider_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/y_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor by complement and carry-in, keep or restore.
module y_div_step
  import y_seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] qreg_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] qreg_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           carry;
  // The remainder MSB is always zero after a restore, so it is shifted out.
  logic           rem_msb_unused;

  assign rem_msb_unused = rem_i[WIDTH];

  // NOTE: every output gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    shifted        = {rem_i[WIDTH-1:0], qreg_i[WIDTH-1]};
    {carry, trial} = {1'b0, shifted} + {1'b0, ~{1'b0, divisor_i}} + {{(WIDTH+1){1'b0}}, 1'b1};
    if (carry) begin
      rem_o  = trial;
      qreg_o = {qreg_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o  = shifted;
      qreg_o = {qreg_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/y_seq_divider.sv
// Multi-cycle unsigned divider: start/ready launch, one quotient bit per clock,
// result presented with a one-cycle valid pulse and held until the next accept.
module y_seq_divider
  import y_seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] qreg_q, qreg_d;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    count_q;
  logic             ready_q, busy_q, valid_q, dz_q;
  logic [WIDTH-1:0] q_q, r_q;

  y_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i    (rem_q),
    .qreg_i   (qreg_q),
    .divisor_i(divisor_q),
    .rem_o    (rem_d),
    .qreg_o   (qreg_d)
  );

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are plain flops, not memories, so resetting them is cheap.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      dz_q      <= 1'b0;
      count_q   <= '0;
      qreg_q    <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            qreg_q    <= a;
            divisor_q <= b;
            rem_q     <= '0;
            count_q   <= '0;
            q_q       <= '0;
            r_q       <= '0;
            dz_q      <= 1'b0;
            ready_q   <= 1'b0;
            if (b == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          rem_q   <= rem_d;
          qreg_q  <= qreg_d;
          count_q <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
          end
        end
        S_DONE: begin
          // A zero divisor skips RUN: quotient saturates, dividend returned as remainder.
          if (divisor_q == '0) begin
            q_q  <= '1;
            r_q  <= qreg_q;
            dz_q <= 1'b1;
          end else begin
            q_q  <= qreg_q;
            r_q  <= rem_q[WIDTH-1:0];
          end
          valid_q <= 1'b1;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign valid = valid_q;
  assign q     = q_q;
  assign r     = r_q;
  assign dz    = dz_q;

endmodule

// File: tb/tb_y_seq_divider.sv
// Bench for y_seq_divider: table vectors, hand-written corner sequences and
// random operands, all checked through a scoreboard of expected results.
module tb_y_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] a, b;
  logic        ready, busy, valid, dz;
  logic [31:0] q, r;

  always #5 clk = ~clk;

  y_seq_divider #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .ready(ready),
    .busy (busy),
    .valid(valid),
    .q    (q),
    .r    (r),
    .dz   (dz)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  exp_t vec[7];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb);
    exp_t e;
    e.a  = ta;
    e.b  = tb;
    e.dz = (tb == 32'd0);
    e.q  = e.dz ? 32'hFFFF_FFFF : ta / tb;
    e.r  = e.dz ? ta : ta % tb;
    return e;
  endfunction

  // Scoreboard consumer: every valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q", q, e.q);
        check("r", r, e.r);
        check("dz", dz, e.dz);
        if (!e.dz)
          check("invariant", ({32'd0, e.a} == {32'd0, q} * {32'd0, e.b} + {32'd0, r}) && (r < e.b), 64'd1);
      end
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, ready, 1);
  endtask

  // Launch one operation and measure accept-to-valid latency and busy cycles.
  task automatic run_op(input exp_t e, input string tag);
    int lat, bc, exp_lat, exp_busy;
    exp_lat  = (e.b == 0) ? 1 : 33;
    exp_busy = (e.b == 0) ? 0 : 32;
    wait_ready(tag);
    a = e.a; b = e.b; start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    bc = 0;
    @(negedge clk);
    if (busy === 1'b1) bc++;
    for (lat = 1; lat <= 100; lat++) begin
      @(negedge clk);
      if (busy === 1'b1) bc++;
      if (valid === 1'b1) break;
    end
    if (lat > 100) begin
      check({tag, "_timeout"}, 64'd1, 64'd0);
      sb.delete();
    end else begin
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_cycles"}, bc, exp_busy);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  seen;
    logic [31:0] ra, rb;

    vec[0] = '{32'd100,        32'd7,          32'd14,         32'd2, 1'b0};
    vec[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0, 1'b0};
    vec[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0, 1'b0};
    vec[3] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5, 1'b1};
    vec[4] = '{32'd3,          32'd10,         32'd0,          32'd3, 1'b0};
    vec[5] = '{32'd0,          32'd9,          32'd0,          32'd0, 1'b0};
    vec[6] = '{32'd1000,       32'd1000,       32'd1,          32'd0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_dz", dz, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_op(vec[i], $sformatf("vec%0d", i));

    // start held high through RUN and DONE: one result, then an immediate re-accept.
    wait_ready("hold");
    a = 32'd50; b = 32'd5; start = 1'b1;
    sb.push_back('{32'd50, 32'd5, 32'd10, 32'd0, 1'b0});
    for (lat = 1; lat <= 100; lat++) begin
      @(negedge clk);
      if (valid === 1'b1) break;
    end
    check("hold_latency", lat, 34);
    sb.push_back('{32'd50, 32'd5, 32'd10, 32'd0, 1'b0});
    @(negedge clk);
    check("hold_reaccept_busy", busy, 1);
    check("hold_reaccept_q_clear", q, 0);
    check("hold_reaccept_valid", valid, 0);
    start = 1'b0;
    for (lat = 1; lat <= 100; lat++) begin
      @(negedge clk);
      if (valid === 1'b1) break;
    end
    check("hold_second_done", lat <= 100, 1);

    // Reset in the middle of RUN discards the operation.
    wait_ready("midrst");
    a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_ready", ready, 1);
    check("midrst_busy_clear", busy, 0);
    check("midrst_q", q, 0);
    check("midrst_r", r, 0);
    check("midrst_valid", valid, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid === 1'b1) seen = 1'b1;
    end
    check("midrst_no_valid", seen, 0);
    run_op(model(32'd9, 32'd2), "after_rst");

    for (int i = 0; i < 1500; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1, 2, 3: rb = $urandom_range(1, 255);
        4:       begin ra = $urandom_range(0, 1000); rb = $urandom; end
        default: rb = $urandom;
      endcase
      run_op(model(ra, rb), "rand");
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
